ahb_interconnect: RTL and testbench
===================================

Name: ahb_interconnect

Overview:
Parametrised AHB-Lite decoder plus response multiplexer for a single master (Cortex-M0 DesignStart) and NSLV slaves. It replaces the fixed 10-slave decoder/mux pair. Added features:
- Address map is set by parameters.
- A built-in default slave returns a proper two-cycle ERROR on unmapped accesses.
- A per-transfer watchdog aborts hung slaves with ERROR and quarantines them until software clears the fault.

Parameters:
- NSLV, 5, number of slaves, 1..16
- BASE, {32'h52000000,32'h51000000,32'h50000000,32'h20000000,32'h00000000}, NSLV×32 flattened base addresses, slave i at bits [32i+31:32i]
- MASK, {32'hFF000000,32'hFF000000,32'hFF000000,32'hF0000000,32'hF0000000}, NSLV×32 flattened address masks
- TIMEOUT, 256, wait-state cycles before watchdog abort, 2..65535
- BAD_DATA, 32'hDEADBEEF, HRDATA driven when no slave owns the data phase

Ports:
- HCLK  input  1  bus clock, 50 MHz
- resetHW  input  1  reset, asynchronous, active-high
- HADDR  input  32  master address
- HTRANS  input  2  master transfer type; only bit 1 used
- HSEL  output  NSLV  slave selects, combinational from HADDR
- HRDATA_S  input  NSLV×32  slave read data, flattened
- HREADYOUT_S  input  NSLV  slave ready outputs
- HRESP_S  input  NSLV  slave error responses
- HRDATA  output  32  read data to master
- HREADY  output  1  ready to master and all slaves
- HRESP  output  1  response to master
- fault_clr  input  1  single-cycle pulse: clears quarantine and sticky status
- timeout_irq  output  1  sticky, set on watchdog abort
- fault_addr  output  32  HADDR of the most recent ERROR transfer (unmapped or timeout)

Behaviour:
- Decode (combinational)
  - HSEL[i] = ((HADDR & MASK_i) == BASE_i) && !quar[i].
  - If several slaves match, only the lowest index is asserted.
  - No match, or the matching slave is quarantined → default slave.
- Data-phase select
  - dsel register (slave index or DEFAULT) loads the decode result when HREADY=1.
  - dsel is held while HREADY=0.
  - Reset value: DEFAULT. addr_q (HADDR) and trans_q (HTRANS[1]) load under the same condition.
- Outputs when dsel=i (no abort in progress): HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
- Outputs when dsel=DEFAULT: HRDATA=BAD_DATA.
  - trans_q=0 (IDLE/BUSY): HREADY=1, HRESP=0.
  - trans_q=1: ERROR sequence.
- Response state machine: IDLE, ERR1, ERR2.
  - IDLE: outputs as above.
  - Enter ERR1 on a default-slave active transfer, or on watchdog expiry.
  - ERR1: HREADY=0, HRESP=1, next state ERR2.
  - ERR2: HREADY=1, HRESP=1, next state IDLE.
  - fault_addr<=addr_q on entry to ERR1.
- Watchdog
  - wcnt (16-bit) clears whenever HREADY=1.
  - wcnt increments while dsel=slave, trans_q=1 and HREADYOUT_S[dsel]=0.
  - When wcnt reaches TIMEOUT-1 and HREADYOUT is still 0: enter ERR1 on the next edge; quar[dsel]<=1; timeout_irq<=1.
  - In ERR1/ERR2 the slave's HREADYOUT and HRESP are ignored.
  - A slave ready on the same cycle wcnt reaches TIMEOUT-1 completes normally, with no abort.
- Quarantine
  - quar[NSLV] register, reset 0.
  - A quarantined slave never gets HSEL; accesses to it take the default-slave ERROR path.
  - fault_clr=1 clears quar and timeout_irq.
  - fault_clr on the same cycle as a new timeout: the set wins.
- Reset values: dsel=DEFAULT, state IDLE, wcnt=0, quar=0, timeout_irq=0, fault_addr=0.
  - Resulting outputs: HREADY=1, HRESP=0, HRDATA=BAD_DATA.
  - Reset mid-transfer forces these values immediately (asynchronous).
- Latency: no added wait states for mapped slaves; the default slave adds exactly 1 wait state.

Test Plan:
- Read HADDR=0x20000010 NONSEQ with RAM HRDATA_S[1]=0x12345678, zero-wait → HSEL=5'b00010; data phase HRDATA=0x12345678, HREADY=1, HRESP=0.
- NONSEQ to 0x60000000 → HSEL=0; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1; fault_addr=0x60000000; HRDATA=0xDEADBEEF.
- IDLE at 0x60000000 → HREADY=1, HRESP=0, no fault_addr update.
- UART (0x51000000) holds HREADYOUT_S[3]=0 indefinitely, TIMEOUT=256 → wait states until cycle 256, then ERR1/ERR2; timeout_irq=1. A later NONSEQ to 0x51000004 gets HSEL[3]=0 and an ERROR. After a fault_clr pulse, the next access asserts HSEL[3]=1.
- GPIO stalls 255 cycles, then HREADYOUT_S[2]=1 → normal OKAY completion, timeout_irq stays 0.
- resetHW asserted during ERR1 → HREADY=1 and HRESP=0 immediately, quar=0, state IDLE after release.

Source files
------------

// File: rtl/ahb_interconnect.sv
// AHB-Lite address decoder and response multiplexer for one master.
// Adds a default ERROR slave, a per-transfer watchdog and slave quarantine.
module ahb_interconnect #(
    parameter int          NSLV     = 5,
    parameter logic [NSLV*32-1:0] BASE = {32'h52000000, 32'h51000000,
                                          32'h50000000, 32'h20000000,
                                          32'h00000000},
    parameter logic [NSLV*32-1:0] MASK = {32'hFF000000, 32'hFF000000,
                                          32'hFF000000, 32'hF0000000,
                                          32'hF0000000},
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
    input  logic             HCLK,
    input  logic             resetHW,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic [NSLV-1:0]  HSEL,
    input  logic [NSLV*32-1:0] HRDATA_S,
    input  logic [NSLV-1:0]  HREADYOUT_S,
    input  logic [NSLV-1:0]  HRESP_S,
    output logic [31:0]      HRDATA,
    output logic             HREADY,
    output logic             HRESP,
    input  logic             fault_clr,
    output logic             timeout_irq,
    output logic [31:0]      fault_addr
);

    localparam int DW = $clog2(NSLV + 1);
    localparam logic [DW-1:0] DEFAULT = DW'(NSLV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ERR1 = 2'd1;
    localparam logic [1:0] S_ERR2 = 2'd2;

    logic [DW-1:0]   dsel_q, dsel_d;
    logic [1:0]      st_q, st_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [NSLV-1:0] quar_q, quar_d;
    logic            irq_q, irq_d;
    logic [31:0]     faddr_q, faddr_d;
    logic [31:0]     addr_q, addr_d;
    logic            trans_q, trans_d;

    logic [NSLV-1:0] hsel_v;
    logic [DW-1:0]   dec_idx;
    logic            dec_def;
    logic            sel_rdy;
    logic            sel_resp;
    logic [31:0]     sel_rdata;
    logic            dsel_slv;
    logic            stalled;
    logic            expire;
    logic            new_err;
    logic            unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Lowest matching slave wins; a quarantined winner falls to default.
    always_comb begin
        hsel_v  = '0;
        dec_idx = DEFAULT;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
                hsel_v    = '0;
                hsel_v[i] = ~quar_q[i];
                dec_idx   = quar_q[i] ? DEFAULT : DW'(i);
            end
        end
    end

    assign HSEL    = hsel_v;
    assign dec_def = (dec_idx == DEFAULT);

    // Route the data-phase slave's response, bad data when none owns it.
    always_comb begin
        sel_rdy   = 1'b1;
        sel_resp  = 1'b0;
        sel_rdata = BAD_DATA;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel_q == DW'(i)) begin
                sel_rdy   = HREADYOUT_S[i];
                sel_resp  = HRESP_S[i];
                sel_rdata = HRDATA_S[32*i +: 32];
            end
        end
    end

    assign dsel_slv = (dsel_q != DEFAULT);
    assign stalled  = (st_q == S_IDLE) && dsel_slv && trans_q && !sel_rdy;
    assign expire   = stalled && (wcnt_q == 16'(TIMEOUT - 1));

    // Master-facing response; abort states override the slave.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = BAD_DATA;
        case (st_q)
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            S_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: begin
                if (dsel_slv) begin
                    HREADY = sel_rdy;
                    HRESP  = sel_resp;
                    HRDATA = sel_rdata;
                end
            end
        endcase
    end

    assign new_err = HREADY && HTRANS[1] && dec_def;

    // Next-state logic for data phase, watchdog, quarantine and status.
    always_comb begin
        st_d    = st_q;
        dsel_d  = dsel_q;
        addr_d  = addr_q;
        trans_d = trans_q;
        wcnt_d  = wcnt_q;
        quar_d  = fault_clr ? '0 : quar_q;
        irq_d   = fault_clr ? 1'b0 : irq_q;
        faddr_d = faddr_q;
        case (st_q)
            S_ERR1:  st_d = S_ERR2;
            S_ERR2:  st_d = new_err ? S_ERR1 : S_IDLE;
            default: st_d = (expire || new_err) ? S_ERR1 : S_IDLE;
        endcase
        if (HREADY) begin
            dsel_d  = dec_idx;
            addr_d  = HADDR;
            trans_d = HTRANS[1];
            wcnt_d  = '0;
        end else if (stalled) begin
            wcnt_d = wcnt_q + 16'd1;
        end
        if (expire) begin
            faddr_d = addr_q;
            irq_d   = 1'b1;
            for (int i = 0; i < NSLV; i++) begin
                if (dsel_q == DW'(i)) quar_d[i] = 1'b1;
            end
        end else if (new_err) begin
            faddr_d = HADDR;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            st_q    <= S_IDLE;
            dsel_q  <= DEFAULT;
            addr_q  <= '0;
            trans_q <= 1'b0;
            wcnt_q  <= '0;
            quar_q  <= '0;
            irq_q   <= 1'b0;
            faddr_q <= '0;
        end else begin
            st_q    <= st_d;
            dsel_q  <= dsel_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            wcnt_q  <= wcnt_d;
            quar_q  <= quar_d;
            irq_q   <= irq_d;
            faddr_q <= faddr_d;
        end
    end

    assign timeout_irq = irq_q;
    assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed testbench for ahb_interconnect with default parameters.
// Drives just after the rising edge and checks once inputs settle.
module tb_ahb_interconnect;

    localparam int NSLV = 5;

    logic              HCLK;
    logic              resetHW;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic [NSLV-1:0]   HSEL;
    logic [NSLV*32-1:0] HRDATA_S;
    logic [NSLV-1:0]   HREADYOUT_S;
    logic [NSLV-1:0]   HRESP_S;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;
    logic              fault_clr;
    logic              timeout_irq;
    logic [31:0]       fault_addr;

    int n_checks;
    int n_errors;

    ahb_interconnect dut (
        .HCLK        (HCLK),
        .resetHW     (resetHW),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL        (HSEL),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .fault_clr   (fault_clr),
        .timeout_irq (timeout_irq),
        .fault_addr  (fault_addr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t);
        HADDR  = a;
        HTRANS = t;
        settle();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        resetHW     = 1'b1;
        HADDR       = '0;
        HTRANS      = 2'b00;
        fault_clr   = 1'b0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < NSLV; i++)
            HRDATA_S[32*i +: 32] = 32'hA0000000 + 32'(i);
        HRDATA_S[63:32] = 32'h12345678;

        // reset state
        step();
        check("rst_hready", 32'(HREADY), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'hDEADBEEF);
        check("rst_irq", 32'(timeout_irq), 32'd0);
        check("rst_faddr", fault_addr, 32'h0);
        step();
        resetHW = 1'b0;

        // decode table
        addr_phase(32'h00000100, 2'b00);
        check("dec_rom", 32'(HSEL), 32'h01);
        addr_phase(32'h50000040, 2'b00);
        check("dec_gpio", 32'(HSEL), 32'h04);
        addr_phase(32'h52FFFFFC, 2'b00);
        check("dec_s4", 32'(HSEL), 32'h10);
        addr_phase(32'h53000000, 2'b00);
        check("dec_none", 32'(HSEL), 32'h00);

        // zero-wait RAM read
        step();
        addr_phase(32'h20000010, 2'b10);
        check("ram_hsel", 32'(HSEL), 32'h02);
        step();
        addr_phase(32'h0, 2'b00);
        check("ram_rdata", HRDATA, 32'h12345678);
        check("ram_hready", 32'(HREADY), 32'd1);
        check("ram_hresp", 32'(HRESP), 32'd0);

        // unmapped NONSEQ
        step();
        addr_phase(32'h60000000, 2'b10);
        check("unm_hsel", 32'(HSEL), 32'h00);
        step();
        addr_phase(32'h0, 2'b00);
        check("unm_err1", {30'd0, HREADY, HRESP}, 32'h1);
        check("unm_rdata", HRDATA, 32'hDEADBEEF);
        step();
        check("unm_err2", {30'd0, HREADY, HRESP}, 32'h3);
        check("unm_faddr", fault_addr, 32'h60000000);
        step();
        check("unm_done", {30'd0, HREADY, HRESP}, 32'h2);

        // IDLE to unmapped: no error, no fault_addr update
        addr_phase(32'h70000000, 2'b00);
        step();
        addr_phase(32'h0, 2'b00);
        check("idle_resp", {30'd0, HREADY, HRESP}, 32'h2);
        step();
        check("idle_faddr", fault_addr, 32'h60000000);

        // GPIO stalls 255 cycles then completes
        HREADYOUT_S[2] = 1'b0;
        HRDATA_S[95:64] = 32'hC0FFEE02;
        addr_phase(32'h50000000, 2'b10);
        check("gpio_hsel", 32'(HSEL), 32'h04);
        step();
        addr_phase(32'h0, 2'b00);
        for (int k = 0; k < 255; k++) begin
            check("gpio_wait", {30'd0, HREADY, HRESP}, 32'h0);
            step();
        end
        HREADYOUT_S[2] = 1'b1;
        settle();
        check("gpio_done", {30'd0, HREADY, HRESP}, 32'h2);
        check("gpio_rdata", HRDATA, 32'hC0FFEE02);
        step();
        check("gpio_irq", 32'(timeout_irq), 32'd0);
        check("gpio_after", {30'd0, HREADY, HRESP}, 32'h2);

        // UART hangs: watchdog abort and quarantine
        HREADYOUT_S[3] = 1'b0;
        addr_phase(32'h51000000, 2'b10);
        check("uart_hsel", 32'(HSEL), 32'h08);
        step();
        addr_phase(32'h0, 2'b00);
        for (int k = 0; k < 256; k++) begin
            check("uart_wait", {30'd0, HREADY, HRESP}, 32'h0);
            step();
        end
        check("uart_err1", {30'd0, HREADY, HRESP}, 32'h1);
        check("uart_irq", 32'(timeout_irq), 32'd1);
        check("uart_faddr", fault_addr, 32'h51000000);
        check("uart_rdata", HRDATA, 32'hDEADBEEF);
        step();
        check("uart_err2", {30'd0, HREADY, HRESP}, 32'h3);
        step();
        check("uart_idle", {30'd0, HREADY, HRESP}, 32'h2);

        addr_phase(32'h51000004, 2'b10);
        check("quar_hsel", 32'(HSEL), 32'h00);
        step();
        addr_phase(32'h0, 2'b00);
        check("quar_err1", {30'd0, HREADY, HRESP}, 32'h1);
        step();
        check("quar_err2", {30'd0, HREADY, HRESP}, 32'h3);
        check("quar_faddr", fault_addr, 32'h51000004);
        step();

        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        settle();
        check("clr_irq", 32'(timeout_irq), 32'd0);
        HREADYOUT_S[3] = 1'b1;
        addr_phase(32'h51000004, 2'b10);
        check("clr_hsel", 32'(HSEL), 32'h08);
        step();
        addr_phase(32'h0, 2'b00);
        check("clr_resp", {30'd0, HREADY, HRESP}, 32'h2);
        check("clr_rdata", HRDATA, 32'hA0000003);
        step();

        // slave 4 times out, reset lands during ERR1
        HREADYOUT_S[4] = 1'b0;
        addr_phase(32'h52000000, 2'b10);
        step();
        addr_phase(32'h0, 2'b00);
        for (int k = 0; k < 256; k++) step();
        check("rst_pre_err1", {30'd0, HREADY, HRESP}, 32'h1);
        check("rst_pre_irq", 32'(timeout_irq), 32'd1);
        resetHW = 1'b1;
        settle();
        check("rst_async", {30'd0, HREADY, HRESP}, 32'h2);
        check("rst_async_irq", 32'(timeout_irq), 32'd0);
        check("rst_async_fa", fault_addr, 32'h0);
        HREADYOUT_S[4] = 1'b1;
        step();
        resetHW = 1'b0;
        settle();
        step();
        check("rst_post", {30'd0, HREADY, HRESP}, 32'h2);
        addr_phase(32'h52000010, 2'b10);
        check("rst_unquar", 32'(HSEL), 32'h10);
        step();
        addr_phase(32'h0, 2'b00);
        check("rst_s4_rdata", HRDATA, 32'hA0000004);
        check("rst_s4_resp", {30'd0, HREADY, HRESP}, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
